// File: rtl/ysyx_22041071_exu_md.sv
// Iterative multiply/divide execution unit with a valid/ready handshake on both sides.
// Shift-add multiply and restoring divide run on operand magnitudes; signs are applied at the end.
module ysyx_22041071_exu_md #(
   parameter int XLEN      = 64,
   parameter int TAG_W     = 5,
   parameter int ITER_BITS = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       op,
   input  logic [XLEN-1:0]  src_a,
   input  logic [XLEN-1:0]  src_b,
   input  logic [TAG_W-1:0] tag_in,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  result,
   output logic [TAG_W-1:0] tag_out,
   output logic             busy
);
   // state | meaning
   // IDLE  | waiting for a request; in_ready high unless flushing or in reset
   // BUSY  | iterating, ITER_BITS result bits per cycle
   // DONE  | result presented, held until out_ready
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam int N     = XLEN / ITER_BITS;
   localparam int N_W   = 32 / ITER_BITS;
   localparam int CNT_W = $clog2(N);
   localparam int WSH   = XLEN - 32;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   function automatic logic [XLEN-1:0] wext(input logic [XLEN-1:0] x);
      return XLEN'($signed(x[31:0]));
   endfunction

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              op_mul, op_w, op_rem, op_high, neg_q, neg_r;
   logic [2*XLEN-1:0] acc, mcand, acc_n, mcand_n, prod;
   logic [XLEN-1:0]   mplier, mplier_n, rem, quo, dvsr, rem_n, quo_n;
   logic [XLEN-1:0]   q_fix, r_fix, fin_res;
   logic [XLEN:0]     rem_x;

   logic              dec_mul, dec_div, dec_w, dec_sgn, dec_rem, dec_high;
   logic [XLEN-1:0]   opa, opb, mag_a, mag_b, spec_res;
   logic              neg_a, neg_b, div_zero, div_ovf, special;

   assign in_ready = (state == IDLE) && !flush && reset;

   always_comb begin
      dec_mul  = 1'b0;
      dec_div  = 1'b0;
      dec_w    = 1'b0;
      dec_sgn  = 1'b0;
      dec_rem  = 1'b0;
      dec_high = 1'b0;
      case (op)
         5'd19: dec_mul = 1'b1;
         5'd20: begin dec_mul = 1'b1; dec_high = 1'b1; dec_sgn = 1'b1; end
         5'd21: begin dec_mul = 1'b1; dec_high = 1'b1; end
         5'd22: begin dec_mul = 1'b1; dec_w = 1'b1; end
         5'd23: begin dec_div = 1'b1; dec_sgn = 1'b1; end
         5'd24: dec_div = 1'b1;
         5'd25: begin dec_div = 1'b1; dec_w = 1'b1; dec_sgn = 1'b1; end
         5'd26: begin dec_div = 1'b1; dec_w = 1'b1; end
         5'd27: begin dec_div = 1'b1; dec_rem = 1'b1; dec_sgn = 1'b1; end
         5'd28: begin dec_div = 1'b1; dec_rem = 1'b1; end
         5'd29: begin dec_div = 1'b1; dec_rem = 1'b1; dec_w = 1'b1; end
         5'd30: begin dec_div = 1'b1; dec_rem = 1'b1; dec_w = 1'b1; dec_sgn = 1'b1; end
         default: ;
      endcase
   end

   // W ops see only the low word, sign- or zero-extended according to the op's signedness.
   always_comb begin
      opa      = dec_w ? (dec_sgn ? wext(src_a) : XLEN'(src_a[31:0])) : src_a;
      opb      = dec_w ? (dec_sgn ? wext(src_b) : XLEN'(src_b[31:0])) : src_b;
      neg_a    = dec_sgn & opa[XLEN-1];
      neg_b    = dec_sgn & opb[XLEN-1];
      mag_a    = neg_a ? -opa : opa;
      mag_b    = neg_b ? -opb : opb;
      div_zero = dec_div & (opb == '0);
      div_ovf  = dec_div & dec_sgn & (dec_w ?
                 ((src_a[31:0] == 32'h8000_0000) && (src_b[31:0] == 32'hFFFF_FFFF)) :
                 ((src_a == MIN_NEG) && (src_b == '1)));
      special  = !(dec_mul | dec_div) | div_zero | div_ovf;
      spec_res = '0;
      if (div_zero)
         spec_res = dec_rem ? (dec_w ? wext(src_a) : src_a) : '1;
      else if (div_ovf)
         spec_res = dec_rem ? '0 : (dec_w ? wext(src_a) : src_a);
   end

   always_comb begin
      acc_n    = acc;
      mcand_n  = mcand;
      mplier_n = mplier;
      rem_n    = rem;
      quo_n    = quo;
      rem_x    = '0;
      for (int i = 0; i < ITER_BITS; i++) begin
         if (mplier_n[0])
            acc_n = acc_n + mcand_n;
         mcand_n  = mcand_n << 1;
         mplier_n = mplier_n >> 1;
         rem_x    = {rem_n, quo_n[XLEN-1]};
         quo_n    = quo_n << 1;
         if (rem_x >= {1'b0, dvsr}) begin
            rem_x    = rem_x - {1'b0, dvsr};
            quo_n[0] = 1'b1;
         end
         rem_n = rem_x[XLEN-1:0];
      end
   end

   always_comb begin
      prod  = neg_q ? -acc_n : acc_n;
      q_fix = neg_q ? -quo_n : quo_n;
      r_fix = neg_r ? -rem_n : rem_n;
      if (op_mul)
         fin_res = op_high ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
      else
         fin_res = op_rem ? r_fix : q_fix;
      if (op_w)
         fin_res = wext(fin_res);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         result    <= '0;
         tag_out   <= '0;
         cnt       <= '0;
      end else if (flush) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               tag_out <= tag_in;
               op_mul  <= dec_mul;
               op_w    <= dec_w;
               op_rem  <= dec_rem;
               op_high <= dec_high;
               neg_q   <= neg_a ^ neg_b;
               neg_r   <= neg_a;
               acc     <= '0;
               mcand   <= (2*XLEN)'(mag_a);
               mplier  <= mag_b;
               rem     <= '0;
               quo     <= dec_w ? (mag_a << WSH) : mag_a;
               dvsr    <= mag_b;
               cnt     <= dec_w ? CNT_W'(N_W - 1) : CNT_W'(N - 1);
               if (special) begin
                  result    <= spec_res;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  busy  <= 1'b1;
                  state <= BUSY;
               end
            end
            BUSY: begin
               acc    <= acc_n;
               mcand  <= mcand_n;
               mplier <= mplier_n;
               rem    <= rem_n;
               quo    <= quo_n;
               cnt    <= cnt - CNT_W'(1);
               if (cnt == '0) begin
                  result    <= fin_res;
                  out_valid <= 1'b1;
                  busy      <= 1'b0;
                  state     <= DONE;
               end
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ysyx_22041071_exu_md.sv
// Scoreboard bench for the multiply/divide unit: driver pushes model results, monitor pops on handshake.
module tb_ysyx_22041071_exu_md;
   localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b0;
   logic [4:0]  op = '0;
   logic [63:0] src_a = '0;
   logic [63:0] src_b = '0;
   logic [4:0]  tag_in = '0;
   logic        in_ready, out_valid, busy;
   logic [63:0] result;
   logic [4:0]  tag_out;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int rdy_mode = 0;

   typedef struct {
      logic [63:0] res;
      logic [4:0]  tag;
      int          lat;
      int          acc_edge;
   } exp_t;
   exp_t exp_q[$];

   ysyx_22041071_exu_md #(.XLEN(64), .TAG_W(5), .ITER_BITS(1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .src_a(src_a), .src_b(src_b), .tag_in(tag_in), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .tag_out(tag_out), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] sx32(input logic [31:0] x);
      return {{32{x[31]}}, x};
   endfunction

   // Reference results straight from the arithmetic definitions of each op.
   function automatic logic [63:0] model(input logic [4:0] o, input logic [63:0] a, input logic [63:0] b);
      logic signed [127:0] ps;
      logic [127:0]        pu;
      logic signed [63:0]  sa, sb;
      logic signed [31:0]  sa32, sb32;
      logic [31:0]         a32, b32;
      logic [63:0]         lo;
      sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
      case (o)
         5'd19: return a * b;
         5'd20: begin ps = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); return ps[127:64]; end
         5'd21: begin pu = {64'd0, a} * {64'd0, b}; return pu[127:64]; end
         5'd22: begin lo = a * b; return sx32(lo[31:0]); end
         5'd23: if (b == 0) return '1; else if (a == MIN64 && b == '1) return a; else return sa / sb;
         5'd24: if (b == 0) return '1; else return a / b;
         5'd25: if (b32 == 0) return '1; else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) return sx32(a32);
                else return sx32(sa32 / sb32);
         5'd26: if (b32 == 0) return '1; else return sx32(a32 / b32);
         5'd27: if (b == 0) return a; else if (a == MIN64 && b == '1) return 0; else return sa % sb;
         5'd28: if (b == 0) return a; else return a % b;
         5'd29: if (b32 == 0) return sx32(a32); else return sx32(a32 % b32);
         5'd30: if (b32 == 0) return sx32(a32); else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) return 0;
                else return sx32(sa32 % sb32);
         default: return 0;
      endcase
   endfunction

   function automatic int model_lat(input logic [4:0] o, input logic [63:0] a, input logic [63:0] b);
      bit w, dv, sg, zero, ovf;
      if (o < 19 || o > 30) return 1;
      w  = (o == 22) || (o == 25) || (o == 26) || (o == 29) || (o == 30);
      dv = (o >= 23);
      sg = (o == 23) || (o == 25) || (o == 27) || (o == 30);
      zero = w ? (b[31:0] == 0) : (b == 0);
      ovf  = sg && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) : (a == MIN64 && b == '1));
      if (dv && (zero || ovf)) return 1;
      return w ? 33 : 65;
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [4:0] o, input logic [63:0] a, input logic [63:0] b, input logic [4:0] t,
                       input bit push, input logic [63:0] er, input int el);
      int n;
      n = 0;
      #1;
      while (!in_ready && n < 400) begin
         step();
         #1;
         n++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
         return;
      end
      op = o; src_a = a; src_b = b; tag_in = t; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      if (push) exp_q.push_back('{res: er, tag: t, lat: el, acc_edge: cyc});
   endtask

   task automatic send_m(input logic [4:0] o, input logic [63:0] a, input logic [63:0] b, input logic [4:0] t);
      send(o, a, b, t, 1'b1, model(o, a, b), model_lat(o, a, b));
   endtask

   function automatic logic [63:0] rnd_operand();
      case ($urandom_range(0, 10))
         0: return 64'd0;
         1: return '1;
         2: return MIN64;
         3: return 64'h0000_0000_8000_0000;
         4: return 64'($urandom_range(1, 20));
         5: return {32'h0, $urandom};
         6: return {$urandom, 32'hFFFF_FFFF};
         7: return {$urandom, 32'h0};
         default: return {$urandom, $urandom};
      endcase
   endfunction

   function automatic logic [4:0] rnd_op();
      if ($urandom_range(0, 15) == 0) return 5'($urandom_range(0, 31));
      return 5'($urandom_range(19, 30));
   endfunction

   // out_ready: 0 = always high, 1 = random, 2 = held low
   initial forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
         1: out_ready = ($urandom_range(0, 3) != 0);
         2: out_ready = 1'b0;
         default: out_ready = 1'b1;
      endcase
   end

   initial begin
      bit          seen, hold_bad, rdy_bad;
      int          first_edge;
      logic [63:0] held_res;
      logic [4:0]  held_tag;
      exp_t        e;
      seen = 0; hold_bad = 0; rdy_bad = 0; first_edge = 0; held_res = '0; held_tag = '0;
      forever begin
         @(negedge clk);
         if (reset === 1'b1 && out_valid === 1'b1) begin
            if (!seen) begin
               seen = 1; first_edge = cyc; held_res = result; held_tag = tag_out;
               hold_bad = 0; rdy_bad = 0;
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_output: out_valid=1 tag=%h result=%h, required no output", tag_out, result);
               end
            end else if (result !== held_res || tag_out !== held_tag) begin
               hold_bad = 1;
            end
            if (in_ready !== 1'b0) rdy_bad = 1;
            if (out_ready) begin
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check64("result", result, e.res);
                  check64("tag_out", 64'(tag_out), 64'(e.tag));
                  check64("latency", 64'(first_edge - e.acc_edge + 1), 64'(e.lat));
                  check64("hold_stable", 64'(hold_bad), 64'd0);
                  check64("in_ready_low_in_done", 64'(rdy_bad), 64'd0);
               end
               seen = 0;
            end
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time exceeded, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset = 1'b0;
      repeat (3) step();
      #1;
      check64("rst_out_valid", 64'(out_valid), 64'd0);
      check64("rst_busy", 64'(busy), 64'd0);
      check64("rst_result", result, 64'd0);
      check64("rst_tag_out", 64'(tag_out), 64'd0);
      check64("rst_in_ready", 64'(in_ready), 64'd0);
      reset = 1'b1;
      step();

      rdy_mode = 0;
      send(5'd19, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 65);
      send(5'd23, 64'h1234, 64'd0, 5'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      send(5'd27, 64'h1234, 64'd0, 5'd3, 1'b1, 64'h1234, 1);
      send(5'd25, 64'h8000_0000, 64'hFFFF_FFFF, 5'd4, 1'b1, 64'hFFFF_FFFF_8000_0000, 1);
      send(5'd30, 64'h8000_0000, 64'hFFFF_FFFF, 5'd5, 1'b1, 64'd0, 1);

      // backpressure: out_ready low at least 5 cycles once the result is up
      rdy_mode = 2;
      send(5'd21, '1, '1, 5'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
      n = 0;
      while (!out_valid && n < 200) begin step(); n++; end
      check64("bp_valid_seen", 64'(out_valid), 64'd1);
      repeat (5) step();
      rdy_mode = 0;

      // flush at the tenth divide iteration
      send(5'd24, {$urandom, $urandom}, 64'($urandom_range(1, 1000)), 5'd7, 1'b0, '0, 0);
      #1;
      check64("busy_in_busy", 64'(busy), 64'd1);
      repeat (9) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      #1;
      check64("flush_in_ready", 64'(in_ready), 64'd1);
      check64("flush_busy", 64'(busy), 64'd0);
      check64("flush_out_valid", 64'(out_valid), 64'd0);
      repeat (70) step();
      send(5'd28, 64'd100, 64'd7, 5'd8, 1'b1, 64'd2, 65);

      // reset for a single edge in the middle of a multiply
      send(5'd19, {$urandom, $urandom}, {$urandom, $urandom}, 5'd9, 1'b0, '0, 0);
      repeat (20) step();
      reset = 1'b0;
      #1;
      check64("in_ready_in_reset", 64'(in_ready), 64'd0);
      step();
      #1;
      check64("midrst_out_valid", 64'(out_valid), 64'd0);
      check64("midrst_busy", 64'(busy), 64'd0);
      check64("midrst_result", result, 64'd0);
      check64("midrst_tag_out", 64'(tag_out), 64'd0);
      reset = 1'b1;
      send(5'd22, 64'h7FFF_FFFF, 64'd2, 5'd10, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 33);

      rdy_mode = 1;
      for (int i = 0; i < 150; i++)
         send_m(rnd_op(), rnd_operand(), rnd_operand(), 5'($urandom_range(0, 31)));
      rdy_mode = 0;

      n = 0;
      while (exp_q.size() > 0 && n < 1000) begin step(); n++; end
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
      end
      repeat (2) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ysyx_22041071_exu_md.md
YSYX_22041071_EXU_MD -- requirements
Module: ysyx_22041071_exu_md

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter TAG_W, default 5, width of the destination-register tag carried with each operation.
REQ-003 SHALL have parameter ITER_BITS, default 1, result bits per iteration; legal values 1 and 2.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-low reset; it is sampled on the rising edge of clk.
REQ-006 SHALL have port in_valid, input, 1, request valid.
REQ-007 SHALL have port in_ready, output, 1, unit can accept a request.
REQ-008 SHALL have port op, input, 5, operation code per REQ-013.
REQ-009 SHALL have ports src_a and src_b, input, XLEN each, operand a (dividend or multiplicand) and operand b.
REQ-010 SHALL have port tag_in, input, TAG_W, destination tag.
REQ-011 SHALL have port flush, input, 1, kills any in-flight operation (branch redirect).
REQ-012 SHALL have ports out_valid (output, 1), out_ready (input, 1), result (output, XLEN), tag_out (output, TAG_W) and busy (output, 1, high in BUSY).

Function
REQ-013 SHALL use the following op codes:
- 19: MUL, low XLEN bits.
- 20: MULH, signed×signed, high bits.
- 21: MULHU, unsigned, high bits.
- 22: MULW.
- 23: DIV.
- 24: DIVU.
- 25: DIVW.
- 26: DIVUW.
- 27: REM.
- 28: REMU.
- 29: REMUW.
- 30: REMW.
REQ-014 SHALL treat any other op as illegal; an illegal op is accepted and produces result 0 after one cycle.
REQ-015 SHALL implement an FSM with states IDLE, BUSY and DONE; in_ready SHALL equal (state==IDLE) && !flush.
REQ-016 SHALL latch op, the operands, tag_in and sign information, and move IDLE->BUSY, on the accept edge (in_valid && in_ready).
REQ-017 SHALL in BUSY perform an iterative shift-add multiply or restoring divide on operand magnitudes, producing ITER_BITS bits per cycle.
REQ-018 SHALL run N = XLEN/ITER_BITS iterations, or N = 32/ITER_BITS for W ops (22, 25, 26, 29, 30), then move BUSY->DONE.
REQ-019 SHALL assert out_valid from the cycle after the last iteration; total latency from accept to out_valid is N+1 cycles.
REQ-020 SHALL apply sign correction to the final product, quotient or remainder when entering DONE; the remainder takes the sign of the dividend.
REQ-021 SHALL, for W ops, use operand bits [31:0] and sign-extend the 32-bit result to XLEN (applies when XLEN=64).
REQ-022 SHALL, on divide by zero, return quotient all-ones and remainder = dividend, skipping BUSY (IDLE->DONE, latency 1 cycle).
REQ-023 SHALL, on signed overflow (most-negative / -1, including the 32-bit case for W ops), return quotient = dividend and remainder 0, with latency 1 cycle.
REQ-024 SHALL hold result and tag_out stable while out_valid && !out_ready.
REQ-025 SHALL go DONE->IDLE on out_ready; a new request cannot be accepted in that same cycle (in_ready is low in DONE).
REQ-026 SHALL, on flush in any state, go to IDLE on the next edge, clear out_valid and discard the operation; flush takes precedence over a simultaneous accept and over a simultaneous out_ready.
REQ-027 SHALL compute the MULH and MULHU high half from the full 2·XLEN-bit product; SHALL NOT truncate the intermediate product.

Reset
REQ-028 SHALL, while reset==0 at a clock edge, set state to IDLE, out_valid 0, busy 0, result 0, tag_out 0 and iteration counter 0.
REQ-029 SHALL, on reset asserted mid-BUSY, abort the operation with no output produced; the first request after reset releases SHALL complete normally.
REQ-030 SHALL hold in_ready low while reset==0.

Verification
REQ-031 SHALL cover MUL with XLEN=64, ITER_BITS=1: a=7, b=-3 -> result 0xFFFF_FFFF_FFFF_FFEB; out_valid 65 cycles after accept.
REQ-032 SHALL cover DIV by zero: a=0x1234, b=0 -> result 0xFFFF_FFFF_FFFF_FFFF, 1 cycle after accept; REM with the same operands -> 0x1234.
REQ-033 SHALL cover DIVW overflow: a=0x8000_0000, b=0xFFFF_FFFF -> result 0xFFFF_FFFF_8000_0000; REMW with the same operands -> 0.
REQ-034 SHALL cover backpressure: MULHU a=b=0xFFFF_FFFF_FFFF_FFFF with out_ready held low 5 cycles -> result 0xFFFF_FFFF_FFFF_FFFE held stable, tag_out unchanged, in_ready low throughout.
REQ-035 SHALL cover flush: flush pulsed at iteration 10 of a DIVU -> out_valid never rises, in_ready high the next cycle, and a following REMU a=100, b=7 -> result 2.
REQ-036 SHALL cover reset: reset driven 0 for one edge mid-BUSY -> all outputs 0 next cycle; after release, a MULW a=0x7FFF_FFFF, b=2 -> result 0xFFFF_FFFF_FFFF_FFFE after 33 cycles.
